// File: rtl/fpadd_arbiter.sv
// Two-requester front end for one shared pipelined FP32 adder; results return in issue order via a tag FIFO.
// Define FPADD_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module fpadd_arbiter #(
    parameter int TAG_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req0_valid,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        req1_ready,
    output logic        add_valid_in,
    output logic [31:0] add_inA,
    output logic [31:0] add_inB,
    input  logic        add_valid_out,
    input  logic [31:0] add_out,
    output logic        res_valid,
    output logic        res_id,
    output logic [31:0] res_data,
    output logic        err
);

    localparam int PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int CNT_W = $clog2(TAG_DEPTH + 1);

    logic [CNT_W-1:0]     count_q, count_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [TAG_DEPTH-1:0] tag_q, tag_d;
    logic                 add_valid_in_q, add_valid_in_d;
    logic [31:0]          add_in_a_q, add_in_a_d;
    logic [31:0]          add_in_b_q, add_in_b_d;
    logic                 res_valid_q, res_valid_d;
    logic                 res_id_q, res_id_d;
    logic [31:0]          res_data_q, res_data_d;
    logic                 err_q, err_d;
`ifdef FPADD_ARB_ROUND_ROBIN_EN
    logic                 rr_q, rr_d;
`endif

    logic full;
    logic gnt0, gnt1;
    logic accept;
    logic pop_ok;

    always_comb begin
        full = (count_q == CNT_W'(TAG_DEPTH));
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!full) begin
`ifdef FPADD_ARB_ROUND_ROBIN_EN
            // rr_q set means requester 1 is favoured on a contested cycle
            if (req0_valid && req1_valid) begin
                gnt0 = !rr_q;
                gnt1 = rr_q;
            end else begin
                gnt0 = req0_valid;
                gnt1 = req1_valid;
            end
`else
            gnt0 = req0_valid;
            gnt1 = req1_valid && !req0_valid;
`endif
        end
        accept = gnt0 || gnt1;
        pop_ok = add_valid_out && (count_q != '0);
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    always_comb begin
        count_d        = count_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        tag_d          = tag_q;
        add_valid_in_d = accept;
        add_in_a_d     = add_in_a_q;
        add_in_b_d     = add_in_b_q;
        res_valid_d    = add_valid_out;
        res_id_d       = res_id_q;
        res_data_d     = res_data_q;
        err_d          = err_q;
`ifdef FPADD_ARB_ROUND_ROBIN_EN
        rr_d           = rr_q;
`endif

        if (accept) begin
            add_in_a_d      = gnt1 ? req1_a : req0_a;
            add_in_b_d      = gnt1 ? req1_b : req0_b;
            tag_d[wr_ptr_q] = gnt1;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
`ifdef FPADD_ARB_ROUND_ROBIN_EN
            rr_d            = gnt0;
`endif
        end

        // A result with no outstanding tag is a protocol error; report it as requester 0
        if (add_valid_out) begin
            res_data_d = add_out;
            if (pop_ok) begin
                res_id_d = tag_q[rd_ptr_q];
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                res_id_d = 1'b0;
                err_d    = 1'b1;
            end
        end

        case ({accept, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_q        <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            tag_q          <= '0;
            add_valid_in_q <= 1'b0;
            add_in_a_q     <= '0;
            add_in_b_q     <= '0;
            res_valid_q    <= 1'b0;
            res_id_q       <= 1'b0;
            res_data_q     <= '0;
            err_q          <= 1'b0;
`ifdef FPADD_ARB_ROUND_ROBIN_EN
            rr_q           <= 1'b0;
`endif
        end else begin
            count_q        <= count_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            tag_q          <= tag_d;
            add_valid_in_q <= add_valid_in_d;
            add_in_a_q     <= add_in_a_d;
            add_in_b_q     <= add_in_b_d;
            res_valid_q    <= res_valid_d;
            res_id_q       <= res_id_d;
            res_data_q     <= res_data_d;
            err_q          <= err_d;
`ifdef FPADD_ARB_ROUND_ROBIN_EN
            rr_q           <= rr_d;
`endif
        end
    end

    assign add_valid_in = add_valid_in_q;
    assign add_inA      = add_in_a_q;
    assign add_inB      = add_in_b_q;
    assign res_valid    = res_valid_q;
    assign res_id       = res_id_q;
    assign res_data     = res_data_q;
    assign err          = err_q;

endmodule
